// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and default parameter values for the
// parametrised register file (regfile_param) and its interface.
//   clr_state_t  - clear-sweep FSM states
//   DEF_*        - default DATA_W / NUM_REGS / NUM_RD
package regfile_pkg;

    typedef enum logic [1:0] {
        CLR_IDLE,
        CLR_SWEEP,
        CLR_FIN
    } clr_state_t;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_NUM_REGS = 8;
    localparam int DEF_NUM_RD   = 2;

endpackage

// File: rtl/regfile_if.sv
// regfile_if: bundles the register-file write, read, reserve and clear
// signals. Clock and reset stay plain ports on the design.
//   master - the datapath driving the register file
//   slave  - the register file itself
// Packed read ports: port i address at RD_ADDR[i*ADDR_W +: ADDR_W],
// data at RD_DATA[i*DATA_W +: DATA_W].
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = DEF_NUM_RD
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic                     LD_REG;
    logic [ADDR_W-1:0]        DR;
    logic [DATA_W-1:0]        BUS;
    logic [NUM_RD*ADDR_W-1:0] RD_ADDR;
    logic [NUM_RD*DATA_W-1:0] RD_DATA;
    logic [NUM_RD-1:0]        RD_READY;
    logic                     RES_REQ;
    logic [ADDR_W-1:0]        RES_ADDR;
    logic [NUM_REGS-1:0]      PENDING;
    logic                     CLR_REQ;
    logic                     CLR_BUSY;
    logic                     CLR_DONE;

    modport master (
        output LD_REG, DR, BUS, RD_ADDR, RES_REQ, RES_ADDR, CLR_REQ,
        input  RD_DATA, RD_READY, PENDING, CLR_BUSY, CLR_DONE
    );

    modport slave (
        input  LD_REG, DR, BUS, RD_ADDR, RES_REQ, RES_ADDR, CLR_REQ,
        output RD_DATA, RD_READY, PENDING, CLR_BUSY, CLR_DONE
    );

endinterface

// File: rtl/regfile_entry.sv
// regfile_entry: one W-bit storage register.
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset (highest priority)
//   clear - synchronous clear to zero (beats load)
//   load  - load d
//   d, q  - data in / stored value
module regfile_entry #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (clear) begin
            data_d = '0;
        end else if (load) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/regfile_param.sv
// regfile_param: parametrised register file, one write port, NUM_RD
// combinational read ports, per-register pending scoreboard and a
// one-entry-per-cycle clear sweep (req/busy/done).
//   Clk   - clock, rising edge
//   Reset - synchronous active-high reset, overrides everything
//   rf    - regfile_if slave: LD_REG/DR/BUS write, RD_ADDR/RD_DATA/
//           RD_READY reads, RES_REQ/RES_ADDR reserve, PENDING,
//           CLR_REQ/CLR_BUSY/CLR_DONE sweep handshake
// Optional build macro REGFILE_BYPASS_EN: write-through forwarding of
// BUS onto read ports addressing DR while idle.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = DEF_NUM_RD
) (
    input  logic     Clk,
    input  logic     Reset,
    regfile_if.slave rf
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    clr_state_t               state_q, state_d;
    logic [ADDR_W-1:0]        idx_q, idx_d;
    logic [NUM_REGS-1:0]      pend_q, pend_d;
    logic [NUM_REGS-1:0]      load, clear;
    logic [DATA_W-1:0]        regs [NUM_REGS];
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_ready;
    logic                     idle;

    assign idle = (state_q == CLR_IDLE);

    // Per-entry decode. Out-of-range DR (non power-of-two NUM_REGS)
    // matches no entry, so the write is dropped naturally.
    always_comb begin
        load  = '0;
        clear = '0;
        for (int unsigned n = 0; n < NUM_REGS; n++) begin
            load[n]  = idle && rf.LD_REG && (rf.DR == ADDR_W'(n));
            clear[n] = (state_q == CLR_SWEEP) && (idx_q == ADDR_W'(n));
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_entry
        regfile_entry #(.W(DATA_W)) u_entry (
            .clk   (Clk),
            .rst   (Reset),
            .load  (load[g]),
            .clear (clear[g]),
            .d     (rf.BUS),
            .q     (regs[g])
        );
    end

    // Scoreboard: reserve is applied after the write-clear so a
    // same-cycle reserve+write leaves the register pending.
    always_comb begin
        pend_d = pend_q;
        for (int unsigned n = 0; n < NUM_REGS; n++) begin
            if (load[n]) begin
                pend_d[n] = 1'b0;
            end
            if (idle && rf.RES_REQ && (rf.RES_ADDR == ADDR_W'(n))) begin
                pend_d[n] = 1'b1;
            end
            if (clear[n]) begin
                pend_d[n] = 1'b0;
            end
        end
    end

    // Sweep FSM
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            CLR_IDLE: begin
                if (rf.CLR_REQ) begin
                    state_d = CLR_SWEEP;
                    idx_d   = '0;
                end
            end
            CLR_SWEEP: begin
                if (idx_q == ADDR_W'(NUM_REGS - 1)) begin
                    state_d = CLR_FIN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            CLR_FIN: begin
                state_d = CLR_IDLE;
            end
            default: begin
                state_d = CLR_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= CLR_IDLE;
            idx_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
        end
    end

    // Read muxes: an address matching no entry reads 0 and ready.
    always_comb begin
        rd_data  = '0;
        rd_ready = '1;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            for (int unsigned n = 0; n < NUM_REGS; n++) begin
                if (rf.RD_ADDR[i*ADDR_W +: ADDR_W] == ADDR_W'(n)) begin
                    rd_data[i*DATA_W +: DATA_W] = regs[n];
                    rd_ready[i]                 = ~pend_q[n];
`ifdef REGFILE_BYPASS_EN
                    // load[n] already implies idle, so no bypass mid-sweep
                    if (load[n]) begin
                        rd_data[i*DATA_W +: DATA_W] = rf.BUS;
                        rd_ready[i]                 = 1'b1;
                    end
`else
`endif
                end
            end
        end
    end

    assign rf.RD_DATA  = rd_data;
    assign rf.RD_READY = rd_ready;
    assign rf.PENDING  = pend_q;
    assign rf.CLR_BUSY = (state_q == CLR_SWEEP);
    assign rf.CLR_DONE = (state_q == CLR_FIN);

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: self-checking bench for regfile_param.
// Default instance (16 bit, 8 regs, 2 ports) is tracked every cycle by
// a reference model; a second instance (32 bit, 6 regs, 3 ports)
// covers out-of-range addressing and a shorter sweep.
module tb_regfile_param;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic Clk;
    logic Reset;

    regfile_if #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(2)) rfi ();
    regfile_if #(.DATA_W(32), .NUM_REGS(6), .NUM_RD(3)) rf6 ();

    regfile_param #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(2)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .rf    (rfi)
    );

    regfile_param #(.DATA_W(32), .NUM_REGS(6), .NUM_RD(3)) dut6 (
        .Clk   (Clk),
        .Reset (Reset),
        .rf    (rf6)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model (default instance) ----------------
    // m_sw: -1 idle, 0..7 = register being cleared this cycle, 8 = done cycle
    logic [15:0] m_reg [8];
    logic [7:0]  m_pend;
    int          m_sw;

    task automatic model_reset();
        for (int n = 0; n < 8; n++) m_reg[n] = '0;
        m_pend = '0;
        m_sw   = -1;
    endtask

    task automatic model_check();
        for (int i = 0; i < 2; i++) begin
            int a;
            logic [15:0] ed;
            logic        er;
            a  = int'(rfi.RD_ADDR[i*3 +: 3]);
            ed = m_reg[a];
            er = ~m_pend[a];
            if (BYP && m_sw < 0 && rfi.LD_REG && int'(rfi.DR) == a) begin
                ed = rfi.BUS;
                er = 1'b1;
            end
            chk($sformatf("model rd_data%0d", i), 64'(rfi.RD_DATA[i*16 +: 16]), 64'(ed));
            chk($sformatf("model rd_ready%0d", i), 64'(rfi.RD_READY[i]), 64'(er));
        end
        chk("model pending", 64'(rfi.PENDING), 64'(m_pend));
        chk("model clr_busy", 64'(rfi.CLR_BUSY), 64'(m_sw >= 0 && m_sw < 8));
        chk("model clr_done", 64'(rfi.CLR_DONE), 64'(m_sw == 8));
    endtask

    task automatic model_edge();
        if (Reset) begin
            model_reset();
        end else if (m_sw < 0) begin
            if (rfi.LD_REG) begin
                m_reg[rfi.DR]  = rfi.BUS;
                m_pend[rfi.DR] = 1'b0;
            end
            if (rfi.RES_REQ) m_pend[rfi.RES_ADDR] = 1'b1;
            if (rfi.CLR_REQ) m_sw = 0;
        end else if (m_sw < 8) begin
            m_reg[m_sw]  = '0;
            m_pend[m_sw] = 1'b0;
            m_sw++;
        end else begin
            m_sw = -1;
        end
    endtask

    // one clock: settle, check model, advance model, cross the edge
    task automatic cyc();
        #2;
        model_check();
        model_edge();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        rfi.LD_REG = 0; rfi.DR = '0; rfi.BUS = '0; rfi.RES_REQ = 0;
        rfi.RES_ADDR = '0; rfi.CLR_REQ = 0;
        rf6.LD_REG = 0; rf6.DR = '0; rf6.BUS = '0; rf6.RES_REQ = 0;
        rf6.RES_ADDR = '0; rf6.CLR_REQ = 0; rf6.RD_ADDR = '0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        ld;
        logic [2:0]  dr;
        logic [15:0] bus;
        logic        res;
        logic [2:0]  resa;
        logic [2:0]  ra0;
        logic [2:0]  ra1;
        logic [15:0] e0;
        logic [15:0] e1;
        logic [1:0]  erdy;
        logic [7:0]  epend;
    } vec_t;

    vec_t tbl [9];

    int busy_n, done_n;

    initial begin
        tbl[0] = '{1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 3'd0, 3'd1, 16'h0000, 16'h0000, 2'b11, 8'h00};
        tbl[1] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd3, 3'd3, 16'hBEEF, 16'hBEEF, 2'b11, 8'h00};
        tbl[2] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd2, 3'd4, 16'h0000, 16'h0000, 2'b11, 8'h00};
        tbl[3] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 3'd3, 3'd5, 16'hBEEF, 16'h0000, 2'b11, 8'h00};
        tbl[4] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd5, 3'd3, 16'h0000, 16'hBEEF, 2'b10, 8'h20};
        tbl[5] = '{1'b1, 3'd5, 16'h0012, 1'b0, 3'd0, 3'd3, 3'd0, 16'hBEEF, 16'h0000, 2'b11, 8'h20};
        tbl[6] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd5, 3'd5, 16'h0012, 16'h0012, 2'b11, 8'h00};
        tbl[7] = '{1'b1, 3'd5, 16'h0034, 1'b1, 3'd5, 3'd3, 3'd3, 16'hBEEF, 16'hBEEF, 2'b11, 8'h00};
        tbl[8] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd5, 3'd0, 16'h0034, 16'h0000, 2'b10, 8'h20};

        idle_inputs();
        rfi.RD_ADDR = '0;
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        model_reset();

        // reset state
        rfi.RD_ADDR = {3'd7, 3'd0};
        #2;
        chk("reset pending", 64'(rfi.PENDING), 64'h0);
        chk("reset busy", 64'(rfi.CLR_BUSY), 64'h0);
        chk("reset done", 64'(rfi.CLR_DONE), 64'h0);
        chk("reset rd_data", 64'(rfi.RD_DATA), 64'h0);
        chk("reset pending6", 64'(rf6.PENDING), 64'h0);

        // table-driven basic write / reserve / read
        for (int v = 0; v < 9; v++) begin
            rfi.LD_REG = tbl[v].ld; rfi.DR = tbl[v].dr; rfi.BUS = tbl[v].bus;
            rfi.RES_REQ = tbl[v].res; rfi.RES_ADDR = tbl[v].resa;
            rfi.RD_ADDR = {tbl[v].ra1, tbl[v].ra0};
            #2;
            chk($sformatf("vec%0d rd0", v), 64'(rfi.RD_DATA[15:0]), 64'(tbl[v].e0));
            chk($sformatf("vec%0d rd1", v), 64'(rfi.RD_DATA[31:16]), 64'(tbl[v].e1));
            chk($sformatf("vec%0d ready", v), 64'(rfi.RD_READY), 64'(tbl[v].erdy));
            chk($sformatf("vec%0d pending", v), 64'(rfi.PENDING), 64'(tbl[v].epend));
            cyc();
        end
        idle_inputs();

        // bypass / write visibility on a pending register
        rfi.LD_REG = 1; rfi.DR = 3'd1; rfi.BUS = 16'h1234; cyc();
        rfi.LD_REG = 0; rfi.RES_REQ = 1; rfi.RES_ADDR = 3'd1; cyc();
        rfi.RES_REQ = 0;
        rfi.LD_REG = 1; rfi.DR = 3'd1; rfi.BUS = 16'hA5A5; rfi.RD_ADDR = {3'd0, 3'd1};
        #2;
        chk("bypass same-cycle data", 64'(rfi.RD_DATA[15:0]), BYP ? 64'hA5A5 : 64'h1234);
        chk("bypass same-cycle ready", 64'(rfi.RD_READY[0]), BYP ? 64'h1 : 64'h0);
        cyc();
        rfi.LD_REG = 0;
        #2;
        chk("write next-cycle data", 64'(rfi.RD_DATA[15:0]), 64'hA5A5);
        chk("write next-cycle ready", 64'(rfi.RD_READY[0]), 64'h1);
        cyc();

        // full sweep with a dropped mid-sweep write
        for (int n = 0; n < 8; n++) begin
            rfi.LD_REG = 1; rfi.DR = 3'(n); rfi.BUS = 16'(n * 16'h1111); cyc();
        end
        rfi.LD_REG = 0;
        rfi.CLR_REQ = 1;
        #2;
        chk("sweep req-cycle busy", 64'(rfi.CLR_BUSY), 64'h0);
        cyc();
        rfi.CLR_REQ = 0;
        for (int j = 1; j <= 8; j++) begin
            rfi.RD_ADDR = {3'((j >= 2) ? j - 2 : 7), 3'(j - 1)};
            if (j == 3) begin
                rfi.LD_REG = 1; rfi.DR = 3'd2; rfi.BUS = 16'h7777;
            end else begin
                rfi.LD_REG = 0;
            end
            #2;
            chk($sformatf("sweep c%0d busy", j), 64'(rfi.CLR_BUSY), 64'h1);
            chk($sformatf("sweep c%0d done", j), 64'(rfi.CLR_DONE), 64'h0);
            chk($sformatf("sweep c%0d uncleared", j), 64'(rfi.RD_DATA[15:0]), 64'(16'((j - 1) * 16'h1111)));
            chk($sformatf("sweep c%0d cleared", j), 64'(rfi.RD_DATA[31:16]), (j >= 2) ? 64'h0 : 64'h7777);
            cyc();
        end
        rfi.LD_REG = 0;
        #2;
        chk("sweep fin done", 64'(rfi.CLR_DONE), 64'h1);
        chk("sweep fin busy", 64'(rfi.CLR_BUSY), 64'h0);
        cyc();
        rfi.RD_ADDR = {3'd7, 3'd2};
        #2;
        chk("after sweep done", 64'(rfi.CLR_DONE), 64'h0);
        chk("after sweep reg2", 64'(rfi.RD_DATA[15:0]), 64'h0);
        chk("after sweep reg7", 64'(rfi.RD_DATA[31:16]), 64'h0);
        cyc();

        // reset during sweep cycle 3
        for (int n = 4; n < 8; n++) begin
            rfi.LD_REG = 1; rfi.DR = 3'(n); rfi.BUS = 16'(16'h4000 + n); cyc();
        end
        rfi.LD_REG = 0; rfi.CLR_REQ = 1; cyc();
        rfi.CLR_REQ = 0;
        cyc(); cyc();
        Reset = 1; cyc();
        Reset = 0;
        for (int p = 0; p < 4; p++) begin
            rfi.RD_ADDR = {3'(2 * p + 1), 3'(2 * p)};
            #1;
            chk($sformatf("abort regs %0d/%0d", 2 * p, 2 * p + 1), 64'(rfi.RD_DATA), 64'h0);
        end
        chk("abort busy", 64'(rfi.CLR_BUSY), 64'h0);
        done_n = 0;
        for (int k = 0; k < 12; k++) begin
            #1;
            done_n += int'(rfi.CLR_DONE);
            cyc();
        end
        chk("abort no done", 64'(done_n), 64'h0);

        // CLR_REQ held across the done cycle restarts a sweep
        rfi.CLR_REQ = 1;
        for (int c = 0; c <= 10; c++) begin
            #1;
            if (c == 9) chk("held fin done", 64'(rfi.CLR_DONE), 64'h1);
            if (c == 10) chk("held idle busy", 64'({rfi.CLR_BUSY, rfi.CLR_DONE}), 64'h0);
            cyc();
        end
        rfi.CLR_REQ = 0;
        #1;
        chk("held restart busy", 64'(rfi.CLR_BUSY), 64'h1);
        cyc();
        repeat (10) cyc();

        // 6-entry / 3-port / 32-bit instance
        for (int n = 0; n < 6; n++) begin
            rf6.LD_REG = 1; rf6.DR = 3'(n); rf6.BUS = 32'hA000_0000 + n; cyc();
        end
        rf6.DR = 3'd6; rf6.BUS = 32'hDEAD_BEEF; rf6.RES_REQ = 1; rf6.RES_ADDR = 3'd7; cyc();
        rf6.LD_REG = 0; rf6.RES_REQ = 0;
        rf6.RD_ADDR = {3'd5, 3'd2, 3'd7};
        #2;
        chk("r6 oor reserve dropped", 64'(rf6.PENDING), 64'h0);
        chk("r6 port0 oor data", 64'(rf6.RD_DATA[31:0]), 64'h0);
        chk("r6 port1 data", 64'(rf6.RD_DATA[63:32]), 64'hA000_0002);
        chk("r6 port2 data", 64'(rf6.RD_DATA[95:64]), 64'hA000_0005);
        chk("r6 ready", 64'(rf6.RD_READY), 64'h7);
        for (int n = 0; n < 6; n++) begin
            rf6.RD_ADDR = {3'd6, 3'(n), 3'd7};
            #1;
            chk($sformatf("r6 reg%0d intact", n), 64'(rf6.RD_DATA[63:32]), 64'(32'hA000_0000 + n));
        end
        cyc();
        rf6.RES_REQ = 1; rf6.RES_ADDR = 3'd4; cyc();
        rf6.RES_REQ = 0;
        rf6.RD_ADDR = {3'd4, 3'd4, 3'd6};
        #2;
        chk("r6 pending4", 64'(rf6.PENDING), 64'h10);
        chk("r6 ready mix", 64'(rf6.RD_READY), 64'h1);
        rf6.CLR_REQ = 1; cyc();
        rf6.CLR_REQ = 0;
        busy_n = 0; done_n = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            busy_n += int'(rf6.CLR_BUSY);
            done_n += int'(rf6.CLR_DONE);
            cyc();
        end
        rf6.RD_ADDR = {3'd0, 3'd4, 3'd5};
        #2;
        chk("r6 sweep busy cycles", 64'(busy_n), 64'd6);
        chk("r6 sweep done pulses", 64'(done_n), 64'd1);
        chk("r6 pending cleared", 64'(rf6.PENDING), 64'h0);
        chk("r6 regs cleared", 64'(rf6.RD_DATA), 64'h0);
        cyc();

        // randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            Reset        = ($urandom_range(0, 249) == 0);
            rfi.LD_REG   = $urandom_range(0, 1) == 1;
            rfi.DR       = 3'($urandom_range(0, 7));
            rfi.BUS      = 16'($urandom);
            rfi.RES_REQ  = ($urandom_range(0, 2) == 0);
            rfi.RES_ADDR = 3'($urandom_range(0, 7));
            rfi.CLR_REQ  = ($urandom_range(0, 29) == 0);
            rfi.RD_ADDR  = 6'($urandom_range(0, 63));
            cyc();
        end
        Reset = 0;
        idle_inputs();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
